// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline stage register with valid/ready handshake, flush and occupancy
// Small circular buffer between two CPU pipeline stages; empty slots present BUBBLE downstream.
module pipe_stage_buf #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [WIDTH-1:0]           inData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [WIDTH-1:0]           outData,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occCount;

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrNext;
  logic [OCC_W-1:0] occNext;

  // Handshake flags depend only on registered occupancy, never on the other side's inputs.
  assign inReady   = (occCount < FULL_OCC);
  assign outValid  = (occCount != '0);
  assign occupancy = occCount;
  assign outData   = outValid ? storage[rdPtr] : BUBBLE;

  assign push = inValid & inReady;
  assign pop  = outValid & outReady;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  always_comb begin
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    if (push) begin
      wrPtrNext = (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
    end
    if (pop) begin
      rdPtrNext = (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
    end
  end

  always_comb begin
    occNext = occCount;
    case ({push, pop})
      2'b10:   occNext = occCount + 1'b1;
      2'b01:   occNext = occCount - 1'b1;
      default: occNext = occCount;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      occCount <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= BUBBLE;
      end
    end else if (flush) begin
      // Stale storage is left in place; the empty rule hides it behind BUBBLE.
      occCount <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else begin
      if (push) begin
        storage[wrPtr] <= inData;
      end
      wrPtr    <= wrPtrNext;
      rdPtr    <= rdPtrNext;
      occCount <= occNext;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf at DEPTH 2 and 3
module tb_pipe_stage_buf;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // DEPTH=2 instance
  logic        rst2, flush2, inValid2, outReady2;
  logic        inReady2, outValid2;
  logic [31:0] inData2, outData2;
  logic [1:0]  occ2;

  // DEPTH=3 instance
  logic        rst3, flush3, inValid3, outReady3;
  logic        inReady3, outValid3;
  logic [31:0] inData3, outData3;
  logic [1:0]  occ3;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .BUBBLE(32'h0)) dut2 (
    .clock(clock), .rst(rst2), .flush(flush2),
    .inValid(inValid2), .inReady(inReady2), .inData(inData2),
    .outValid(outValid2), .outReady(outReady2), .outData(outData2),
    .occupancy(occ2)
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .BUBBLE(32'h0)) dut3 (
    .clock(clock), .rst(rst3), .flush(flush3),
    .inValid(inValid3), .inReady(inReady3), .inData(inData3),
    .outValid(outValid3), .outReady(outReady3), .outData(outData3),
    .occupancy(occ3)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst3 = 1'b1;
    inValid2 = 1'b1; inData2 = 32'hDEAD;
    step();
    rst2 = 1'b0; rst3 = 1'b0;
    inValid2 = 1'b0;
    checks++; if (outValid2 !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b exp=0", outValid2); end
    checks++; if (inReady2 !== 1'b1) begin failures++; $display("FAIL reset_inReady got=%b exp=1", inReady2); end
    checks++; if (occ2 !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ2); end
    checks++; if (outData2 !== 32'h0) begin failures++; $display("FAIL reset_outData got=%h exp=0", outData2); end
    checks++; if (outValid3 !== 1'b0 || occ3 !== 2'd0 || outData3 !== 32'h0) begin
      failures++; $display("FAIL reset_d3 got=%b/%0d/%h exp=0/0/0", outValid3, occ3, outData3);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    outReady2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inValid2 = 1'b1; inData2 = vals[i];
      step();
      checks++; if (outData2 !== vals[i] || outValid2 !== 1'b1) begin
        failures++; $display("FAIL stream_data%0d got=%h/%b exp=%h/1", i, outData2, outValid2, vals[i]);
      end
      checks++; if (occ2 !== 2'd1) begin failures++; $display("FAIL stream_occ%0d got=%0d exp=1", i, occ2); end
    end
    inValid2 = 1'b0;
    step();
    checks++; if (occ2 !== 2'd0 || outData2 !== 32'h0) begin
      failures++; $display("FAIL stream_drain got=%0d/%h exp=0/0", occ2, outData2);
    end
  endtask

  task automatic test_backpressure();
    outReady2 = 1'b0;
    inValid2 = 1'b1; inData2 = 32'hA1;
    step();
    checks++; if (occ2 !== 2'd1 || inReady2 !== 1'b1 || outData2 !== 32'hA1) begin
      failures++; $display("FAIL bp_first got=%0d/%b/%h exp=1/1/a1", occ2, inReady2, outData2);
    end
    inData2 = 32'hA2;
    step();
    checks++; if (occ2 !== 2'd2 || inReady2 !== 1'b0) begin
      failures++; $display("FAIL bp_full got=%0d/%b exp=2/0", occ2, inReady2);
    end
    inData2 = 32'hA3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (occ2 !== 2'd2 || outData2 !== 32'hA1 || outValid2 !== 1'b1) begin
        failures++; $display("FAIL bp_hold%0d got=%0d/%h exp=2/a1", i, occ2, outData2);
      end
    end
  endtask

  task automatic test_release();
    outReady2 = 1'b1;
    step();
    checks++; if (outData2 !== 32'hA2 || occ2 !== 2'd1 || inReady2 !== 1'b1) begin
      failures++; $display("FAIL rel_pop1 got=%h/%0d/%b exp=a2/1/1", outData2, occ2, inReady2);
    end
    step();
    checks++; if (outData2 !== 32'hA3 || occ2 !== 2'd1) begin
      failures++; $display("FAIL rel_pop2 got=%h/%0d exp=a3/1", outData2, occ2);
    end
    inValid2 = 1'b0;
    step();
    checks++; if (occ2 !== 2'd0 || outValid2 !== 1'b0) begin
      failures++; $display("FAIL rel_empty got=%0d/%b exp=0/0", occ2, outValid2);
    end
  endtask

  task automatic test_flush();
    outReady2 = 1'b0;
    inValid2 = 1'b1; inData2 = 32'h55;
    step();
    inData2 = 32'h66;
    step();
    checks++; if (occ2 !== 2'd2) begin failures++; $display("FAIL flush_fill got=%0d exp=2", occ2); end
    flush2 = 1'b1; inData2 = 32'hFF; outReady2 = 1'b1;
    step();
    checks++; if (occ2 !== 2'd0 || outValid2 !== 1'b0 || outData2 !== 32'h0) begin
      failures++; $display("FAIL flush_full got=%0d/%b/%h exp=0/0/0", occ2, outValid2, outData2);
    end
    // flush with a slot free: the same-cycle push must still be discarded
    step();
    checks++; if (occ2 !== 2'd0 || outData2 !== 32'h0) begin
      failures++; $display("FAIL flush_push got=%0d/%h exp=0/0", occ2, outData2);
    end
    flush2 = 1'b0; inValid2 = 1'b0;
    step();
    checks++; if (outValid2 !== 1'b0 || outData2 !== 32'h0) begin
      failures++; $display("FAIL flush_after got=%b/%h exp=0/0", outValid2, outData2);
    end
    inValid2 = 1'b1; inData2 = 32'h77; outReady2 = 1'b0;
    step();
    inValid2 = 1'b0;
    checks++; if (outData2 !== 32'h77 || occ2 !== 2'd1) begin
      failures++; $display("FAIL flush_restart got=%h/%0d exp=77/1", outData2, occ2);
    end
  endtask

  task automatic test_wrap_reset();
    logic [9:0]  ivPat;
    logic [9:0]  orPat;
    logic [31:0] q [$];
    logic        doPush, doPop;
    ivPat = 10'b1011101111;   // bit i = cycle i
    orPat = 10'b1111011000;
    for (int i = 0; i < 10; i++) begin
      inValid3 = ivPat[i]; outReady3 = orPat[i]; inData3 = 32'h60 + i;
      doPush = ivPat[i] && (q.size() < 3);
      doPop  = orPat[i] && (q.size() > 0);
      checks++; if (inReady3 !== (q.size() < 3)) begin
        failures++; $display("FAIL wrap_inReady%0d got=%b exp=%b", i, inReady3, q.size() < 3);
      end
      step();
      if (doPop) void'(q.pop_front());
      if (doPush) q.push_back(32'h60 + i);
      checks++; if (occ3 !== 2'(q.size()) || outData3 !== ((q.size() != 0) ? q[0] : 32'h0)) begin
        failures++; $display("FAIL wrap_cycle%0d got=%0d/%h exp=%0d/%h", i, occ3, outData3,
                             q.size(), (q.size() != 0) ? q[0] : 32'h0);
      end
    end
    rst3 = 1'b1; inValid3 = 1'b1; inData3 = 32'hEE; outReady3 = 1'b0;
    step();
    rst3 = 1'b0; inValid3 = 1'b0;
    checks++; if (occ3 !== 2'd0 || outValid3 !== 1'b0 || inReady3 !== 1'b1 || outData3 !== 32'h0) begin
      failures++; $display("FAIL wrap_reset got=%0d/%b/%b/%h exp=0/0/1/0", occ3, outValid3, inReady3, outData3);
    end
    inValid3 = 1'b1; inData3 = 32'h90;
    step();
    inData3 = 32'h91;
    step();
    inValid3 = 1'b0; outReady3 = 1'b1;
    checks++; if (outData3 !== 32'h90 || occ3 !== 2'd2) begin
      failures++; $display("FAIL wrap_post0 got=%h/%0d exp=90/2", outData3, occ3);
    end
    step();
    checks++; if (outData3 !== 32'h91 || occ3 !== 2'd1) begin
      failures++; $display("FAIL wrap_post1 got=%h/%0d exp=91/1", outData3, occ3);
    end
  endtask

  initial begin
    rst2 = 1'b1; flush2 = 1'b0; inValid2 = 1'b0; outReady2 = 1'b0; inData2 = '0;
    rst3 = 1'b1; flush3 = 1'b0; inValid3 = 1'b0; outReady3 = 1'b0; inData3 = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_release();
    test_flush();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
